time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, meaning CLK100MHZ cycles per second (benches override with small values).
REQ-002 SHALL have port CLK100MHZ  input  1  system clock; the block has one clock, and all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port MButton  input  1  debounced minute-set button, level, active-high, synchronous to CLK100MHZ.
REQ-005 SHALL have port HButton  input  1  debounced hour-set button, level, active-high, synchronous to CLK100MHZ.
REQ-006 SHALL have port hours2  output  4  BCD tens of hours, 0..2.
REQ-007 SHALL have port hours1  output  4  BCD units of hours, 0..9.
REQ-008 SHALL have port mins2  output  4  BCD tens of minutes, 0..5.
REQ-009 SHALL have port mins1  output  4  BCD units of minutes, 0..9.
REQ-010 SHALL have port SecTick  output  1  one-cycle pulse when the seconds count advances.
REQ-011 SHALL have port Colon  output  1  high while the seconds count is even.

Function
REQ-012 Prescaler SHALL count 0..TICKS_PER_SEC-1, wrap to 0, and assert SecTick (registered) on the cycle after the count wraps.
REQ-013 Seconds SHALL be a 6-bit binary counter 0..59 that advances on every prescaler wrap.
REQ-014 Seconds wrapping 59->0 SHALL cause an automatic minute advance in the same update.
REQ-015 Minute advance SHALL step the BCD pair mins2:mins1 by one; mins1 9->0 carries into mins2; 59->00 generates an hour carry.
REQ-016 Hour advance SHALL step the BCD pair hours2:hours1 by one; hours1 9->0 carries into hours2; 23->00 wraps without further carry.
REQ-017 Each button SHALL be edge-detected internally (registered previous value); only a 0->1 transition counts as a press, and holding a button produces exactly one press.
REQ-018 MButton press SHALL advance minutes by one with NO hour carry (59->00 leaves hours unchanged), and SHALL clear seconds and prescaler to 0.
REQ-019 HButton press SHALL advance hours by one (23->00) and SHALL NOT affect minutes, seconds or prescaler.
REQ-020 MButton press and prescaler wrap in the same cycle: press wins; prescaler and seconds clear; minutes advance exactly once; SecTick is not asserted.
REQ-021 HButton press and automatic hour carry in the same cycle SHALL advance hours by exactly one.
REQ-022 MButton and HButton presses in the same cycle SHALL both apply independently per REQ-018/REQ-019.
REQ-023 All time outputs SHALL be registered and reflect an advance on the first rising edge after the triggering condition; they SHALL never hold a non-BCD or out-of-range value.
REQ-024 Colon SHALL be driven from the seconds register LSB, inverted (high when even).

Reset
REQ-025 Reset asserted SHALL immediately, without waiting for a clock edge, force hours2=hours1=mins2=mins1=0, seconds=0, prescaler=0, SecTick=0, Colon=1, and both button edge registers to 0.
REQ-026 Reset asserted mid-count or mid-press SHALL discard all pending advances; after deassertion, a button already held high SHALL count as a press on the first clock edge after deassertion.
REQ-027 After Reset deasserts, the first SecTick SHALL occur TICKS_PER_SEC cycles later.

Verification (TICKS_PER_SEC=4)
REQ-028 Reset release, idle 240 cycles -> outputs 0,0,0,1 (00:01), 60 SecTick pulses observed, Colon toggles every 4 cycles.
REQ-029 Preload 23:59 by presses, run to seconds=59 then one more tick -> 00:00, and no spurious carry.
REQ-030 At 10:59, pulse MButton -> 10:00 with hours unchanged and seconds=0; hold MButton 20 cycles -> only one advance.
REQ-031 At 23:xx, pulse HButton -> 00:xx; at 09:xx pulse HButton -> 10:xx (BCD carry).
REQ-032 At 12:59:59, press HButton on the cycle of the prescaler wrap -> 13:00 (a single hour advance).
REQ-033 Assert Reset asynchronously between clock edges at 17:42 -> outputs read 00:00 before the next edge; MButton held through release -> 00:01 one cycle after release.

Source files
------------

// File: rtl/time_keeper.sv
// time_keeper: 24-hour HH:MM clock with a hidden seconds counter.
// A prescaler divides CLK100MHZ down to one tick per second; seconds roll
// into minutes and minutes into hours. Two set buttons let the user advance
// minutes (which also restarts the current minute) and hours independently.
module time_keeper #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic       MButton,
    input  logic       HButton,
    output logic [3:0] hours2,
    output logic [3:0] hours1,
    output logic [3:0] mins2,
    output logic [3:0] mins1,
    output logic       SecTick,
    output logic       Colon
);

    // A one-tick-per-cycle configuration still needs a 1-bit prescaler.
    localparam int                 PRESC_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    // ------------------------------------------------------------------
    // BCD helpers. Any out-of-range pair is treated as corrupt and forced
    // back to 00 so the display can never show an illegal time.
    // ------------------------------------------------------------------
    function automatic logic min_valid(input logic [3:0] tens, input logic [3:0] ones);
        logic ok;
        ok = (tens <= 4'd5) && (ones <= 4'd9);
        return ok;
    endfunction

    function automatic logic hour_valid(input logic [3:0] tens, input logic [3:0] ones);
        logic ok;
        if (tens <= 4'd1) begin
            ok = (ones <= 4'd9);
        end else if (tens == 4'd2) begin
            ok = (ones <= 4'd3);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Next minute value, 59 wraps to 00.
    function automatic logic [7:0] min_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if (!min_valid(tens, ones)) begin
            res = 8'h00;
        end else if (ones == 4'd9) begin
            if (tens == 4'd5) begin
                res = 8'h00;
            end else begin
                res = {tens + 4'd1, 4'd0};
            end
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    // Next hour value, 23 wraps to 00.
    function automatic logic [7:0] hour_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if (!hour_valid(tens, ones)) begin
            res = 8'h00;
        end else if ((tens == 4'd2) && (ones == 4'd3)) begin
            res = 8'h00;
        end else if (ones == 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_r;
    logic [5:0]         sec_r;
    logic [3:0]         hours2_r;
    logic [3:0]         hours1_r;
    logic [3:0]         mins2_r;
    logic [3:0]         mins1_r;
    logic               sectick_r;
    logic               colon_r;
    logic               mbtn_prev_r;
    logic               hbtn_prev_r;

    logic [PRESC_W-1:0] presc_next_s;
    logic [5:0]         sec_next_s;
    logic               sectick_next_s;
    logic               min_adv_s;
    logic               min_carry_en_s;
    logic [7:0]         mins_next_s;
    logic               hour_carry_s;
    logic               hour_adv_s;
    logic [7:0]         hours_next_s;
    logic               colon_next_s;

    logic               m_press_s;
    logic               h_press_s;
    logic               presc_wrap_s;
    logic               sec_at_top_s;
    logic               min_at_top_s;

    // Rising edge of a button level is a press; holding it gives only one.
    assign m_press_s    = MButton & ~mbtn_prev_r;
    assign h_press_s    = HButton & ~hbtn_prev_r;
    // ">=" also recovers a prescaler that somehow lands beyond its range.
    assign presc_wrap_s = (presc_r >= PRESC_MAX);
    assign sec_at_top_s = (sec_r >= 6'd59);
    assign min_at_top_s = (mins2_r == 4'd5) && (mins1_r == 4'd9);

    // Prescaler, seconds and tick: a minute-set press restarts the minute
    // and takes priority over a coincident prescaler wrap.
    always_comb begin
        presc_next_s   = presc_r;
        sec_next_s     = sec_r;
        sectick_next_s = 1'b0;
        min_adv_s      = 1'b0;
        min_carry_en_s = 1'b0;
        if (m_press_s) begin
            presc_next_s = '0;
            sec_next_s   = 6'd0;
            min_adv_s    = 1'b1;
        end else if (presc_wrap_s) begin
            presc_next_s   = '0;
            sectick_next_s = 1'b1;
            if (sec_at_top_s) begin
                sec_next_s     = 6'd0;
                min_adv_s      = 1'b1;
                min_carry_en_s = 1'b1;
            end else begin
                sec_next_s = sec_r + 6'd1;
            end
        end else begin
            presc_next_s = presc_r + PRESC_ONE;
            sec_next_s   = (sec_r > 6'd59) ? 6'd0 : sec_r;
        end
    end

    // Minutes: only an automatic rollover (not a button press) carries into hours.
    always_comb begin
        mins_next_s  = {mins2_r, mins1_r};
        hour_carry_s = 1'b0;
        if (min_adv_s) begin
            mins_next_s  = min_inc(mins2_r, mins1_r);
            hour_carry_s = min_carry_en_s & min_at_top_s;
        end else if (min_valid(mins2_r, mins1_r)) begin
            mins_next_s = {mins2_r, mins1_r};
        end else begin
            mins_next_s = 8'h00;
        end
    end

    // Hours: a press and a carry in the same cycle still advance only once.
    always_comb begin
        hour_adv_s   = h_press_s | hour_carry_s;
        hours_next_s = {hours2_r, hours1_r};
        if (hour_adv_s) begin
            hours_next_s = hour_inc(hours2_r, hours1_r);
        end else if (hour_valid(hours2_r, hours1_r)) begin
            hours_next_s = {hours2_r, hours1_r};
        end else begin
            hours_next_s = 8'h00;
        end
    end

    // Colon follows the parity of the seconds value being loaded.
    always_comb begin
        colon_next_s = ~sec_next_s[0];
    end

    // State register with asynchronous clear of every counter and edge detector.
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            presc_r     <= '0;
            sec_r       <= 6'd0;
            hours2_r    <= 4'd0;
            hours1_r    <= 4'd0;
            mins2_r     <= 4'd0;
            mins1_r     <= 4'd0;
            sectick_r   <= 1'b0;
            colon_r     <= 1'b1;
            mbtn_prev_r <= 1'b0;
            hbtn_prev_r <= 1'b0;
        end else begin
            presc_r     <= presc_next_s;
            sec_r       <= sec_next_s;
            hours2_r    <= hours_next_s[7:4];
            hours1_r    <= hours_next_s[3:0];
            mins2_r     <= mins_next_s[7:4];
            mins1_r     <= mins_next_s[3:0];
            sectick_r   <= sectick_next_s;
            colon_r     <= colon_next_s;
            mbtn_prev_r <= MButton;
            hbtn_prev_r <= HButton;
        end
    end

    assign hours2  = hours2_r;
    assign hours1  = hours1_r;
    assign mins2   = mins2_r;
    assign mins1   = mins1_r;
    assign SecTick = sectick_r;
    assign Colon   = colon_r;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper with a small TICKS_PER_SEC.
// A behavioural clock model (plain integer hours/minutes/seconds) is stepped
// alongside the DUT every cycle; directed tables and sequences add fixed
// expectations for the corner cases.
module tb_time_keeper;

    localparam int T = 4;

    logic       CLK100MHZ = 1'b0;
    logic       Reset     = 1'b0;
    logic       MButton   = 1'b0;
    logic       HButton   = 1'b0;
    logic [3:0] hours2, hours1, mins2, mins1;
    logic       SecTick, Colon;

    time_keeper #(.TICKS_PER_SEC(T)) dut (
        .CLK100MHZ(CLK100MHZ),
        .Reset    (Reset),
        .MButton  (MButton),
        .HButton  (HButton),
        .hours2   (hours2),
        .hours1   (hours1),
        .mins2    (mins2),
        .mins1    (mins1),
        .SecTick  (SecTick),
        .Colon    (Colon)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int   m_h, m_m, m_s, m_p;
    logic m_tick;
    logic mb_prev, hb_prev;

    typedef struct {
        logic mb;
        logic hb;
        int   n;
        int   exp_h;
        int   exp_m;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] time_vec(input int h, input int m, input logic tick, input logic colon);
        logic [3:0] h2, h1, n2, n1;
        h2 = 4'(h / 10);
        h1 = 4'(h % 10);
        n2 = 4'(m / 10);
        n1 = 4'(m % 10);
        return {14'd0, h2, h1, n2, n1, tick, colon};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {14'd0, hours2, hours1, mins2, mins1, SecTick, Colon};
    endfunction

    function automatic logic [31:0] time_only(input logic [31:0] v);
        return v & 32'h0003_FFFC;
    endfunction

    function automatic logic [31:0] model_vec();
        return time_vec(m_h, m_m, m_tick, ((m_s % 2) == 0));
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_p = 0;
        m_tick = 1'b0; mb_prev = 1'b0; hb_prev = 1'b0;
    endtask

    // One clock of the clock rules, written on whole-number time fields.
    task automatic model_step(input logic mb, input logic hb);
        logic mp, hp, carry;
        mp = mb & ~mb_prev;
        hp = hb & ~hb_prev;
        carry  = 1'b0;
        m_tick = 1'b0;
        if (mp) begin
            m_p = 0;
            m_s = 0;
            m_m = (m_m + 1) % 60;
        end else if (m_p == T - 1) begin
            m_p = 0;
            m_tick = 1'b1;
            m_s = (m_s + 1) % 60;
            if (m_s == 0) begin
                carry = (m_m == 59);
                m_m = (m_m + 1) % 60;
            end
        end else begin
            m_p = m_p + 1;
        end
        if (hp || carry) m_h = (m_h + 1) % 24;
        mb_prev = mb;
        hb_prev = hb;
    endtask

    task automatic step(input logic mb, input logic hb);
        MButton = mb;
        HButton = hb;
        @(posedge CLK100MHZ);
        model_step(mb, hb);
        #1;
        chk("cycle", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #2;
        chk("reset_async", dut_vec(), time_vec(0, 0, 1'b0, 1'b1));
        @(posedge CLK100MHZ);
        #3;
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic press_h(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
    endtask

    task automatic press_m(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    // Idle until the next edge will be the prescaler wrap with seconds at 59.
    task automatic run_to_wrap59();
        int guard;
        guard = 0;
        while (!(m_s == 59 && m_p == T - 1) && guard < 400) begin
            step(1'b0, 1'b0);
            guard++;
        end
        if (guard >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL wrap59_timeout: got no 59s wrap within %0d cycles", guard);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, toggles, first_tick;
        logic prev_colon;

        tbl[0] = '{1'b0, 1'b1, 1,  1, 0};
        tbl[1] = '{1'b0, 1'b0, 1,  1, 0};
        tbl[2] = '{1'b0, 1'b1, 10, 2, 0};
        tbl[3] = '{1'b0, 1'b0, 1,  2, 0};
        tbl[4] = '{1'b1, 1'b0, 1,  2, 1};
        tbl[5] = '{1'b1, 1'b0, 20, 2, 1};
        tbl[6] = '{1'b0, 1'b0, 1,  2, 1};
        tbl[7] = '{1'b1, 1'b1, 1,  3, 2};
        tbl[8] = '{1'b0, 1'b0, 1,  3, 2};
        tbl[9] = '{1'b0, 1'b1, 1,  4, 2};

        model_reset();
        #1;
        do_reset();

        // table of button patterns
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].mb, tbl[i].hb);
            chk("table", time_only(dut_vec()), time_vec(tbl[i].exp_h, tbl[i].exp_m, 1'b0, 1'b0));
        end

        // idle minute from reset: 60 ticks, first after T cycles, colon flips per tick
        do_reset();
        ticks = 0; toggles = 0; first_tick = 0; prev_colon = Colon;
        for (int i = 1; i <= 240; i++) begin
            step(1'b0, 1'b0);
            if (SecTick) begin
                ticks++;
                if (first_tick == 0) first_tick = i;
            end
            if (Colon != prev_colon) toggles++;
            prev_colon = Colon;
        end
        chk("idle_time", time_only(dut_vec()), time_vec(0, 1, 1'b0, 1'b0));
        chk("idle_ticks", ticks, 60);
        chk("first_tick", first_tick, T);
        chk("colon_toggles", toggles, 60);

        // 23:59:59 rolls to 00:00 with no extra carry
        do_reset();
        press_h(23);
        press_m(59);
        chk("preload_2359", time_only(dut_vec()), time_vec(23, 59, 1'b0, 1'b0));
        run_to_wrap59();
        chk("pre_roll", time_only(dut_vec()), time_vec(23, 59, 1'b0, 1'b0));
        step(1'b0, 1'b0);
        chk("day_roll", dut_vec(), time_vec(0, 0, 1'b1, 1'b1));
        repeat (8) step(1'b0, 1'b0);
        chk("no_spurious", time_only(dut_vec()), time_vec(0, 0, 1'b0, 1'b0));

        // minute button at 10:59: no hour carry, seconds cleared, hold = one press
        do_reset();
        press_h(10);
        press_m(59);
        repeat (9) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("mbtn_nocarry", dut_vec(), time_vec(10, 0, 1'b0, 1'b1));
        step(1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("mbtn_hold", time_only(dut_vec()), time_vec(10, 1, 1'b0, 1'b0));

        // hour button wrap and BCD carry
        do_reset();
        press_h(23);
        chk("h_23", time_only(dut_vec()), time_vec(23, 0, 1'b0, 1'b0));
        press_h(1);
        chk("h_wrap", time_only(dut_vec()), time_vec(0, 0, 1'b0, 1'b0));
        press_h(9);
        chk("h_09", time_only(dut_vec()), time_vec(9, 0, 1'b0, 1'b0));
        press_h(1);
        chk("h_bcd", time_only(dut_vec()), time_vec(10, 0, 1'b0, 1'b0));

        // hour press coinciding with automatic hour carry, then minute press on a wrap
        do_reset();
        press_h(12);
        press_m(59);
        run_to_wrap59();
        step(1'b0, 1'b1);
        chk("h_press_carry", dut_vec(), time_vec(13, 0, 1'b1, 1'b1));
        step(1'b0, 1'b0);
        run_to_wrap59();
        step(1'b1, 1'b0);
        chk("m_press_wrap", dut_vec(), time_vec(13, 1, 1'b0, 1'b1));
        step(1'b0, 1'b0);

        // asynchronous reset between edges at 17:42, minute button held through release
        do_reset();
        press_h(17);
        press_m(42);
        chk("preload_1742", time_only(dut_vec()), time_vec(17, 42, 1'b0, 1'b0));
        #2;
        Reset   = 1'b1;
        MButton = 1'b1;
        #1;
        chk("mid_reset", dut_vec(), time_vec(0, 0, 1'b0, 1'b1));
        @(posedge CLK100MHZ);
        #3;
        Reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0);
        chk("held_after_reset", time_only(dut_vec()), time_vec(0, 1, 1'b0, 1'b0));
        step(1'b0, 1'b0);

        // random buttons, busy phase then mostly idle with occasional hour presses
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
